// File: rtl/run_det_pkg.sv
// Shared types and helpers for the serial run-length detector.
// State encoding, mode codes and polarity qualification.
package run_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MATCH
  } state_t;

  localparam logic [1:0] MODE_ANY   = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  function automatic logic allowed(
    input logic [1:0] m,
    input logic       b
  );
    logic r;
    r = 1'b0;
    unique case (m)
      MODE_ANY:   r = 1'b1;
      MODE_ONES:  r = b;
      MODE_ZEROS: r = ~b;
      MODE_OFF:   r = 1'b0;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr and inc together load the value 1.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         max_en,
  input  logic [W-1:0] max,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : q_q;
    q_d  = base;
    if (inc && !(max_en && (base == max))) begin
      q_d = base + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/run_length_detector.sv
// Serial run-length detector with polarity qualification,
// one-cycle match pulse and saturating match counter.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int LEN_W   = $clog2(RUN_LEN + 1),
  parameter int HIT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clear_hits,
  output logic             z,
  output logic             z_pulse,
  output logic             run_bit,
  output logic [LEN_W-1:0] run_len,
  output logic [HIT_W-1:0] hit_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic             run_bit_q;
  logic             run_bit_d;
  logic             z_q;
  logic             z_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             new_run;
  logic             hit_inc;
  logic [LEN_W-1:0] run_len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      run_bit_q <= 1'b0;
      z_q       <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_bit_q <= run_bit_d;
      z_q       <= z_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_bit_d = run_bit_q;
    new_run   = 1'b0;
    if (en) begin
      new_run   = (state_q == S_IDLE) || (w != run_bit_q);
      run_bit_d = w;
      unique case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN: begin
          if (new_run) begin
            state_d = S_RUN;
          end else if (run_len_q == LEN_W'(RUN_LEN - 1)) begin
            state_d = S_MATCH;
          end else begin
            state_d = S_RUN;
          end
        end
        S_MATCH: state_d = new_run ? S_RUN : S_MATCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Mode only gates the outputs; the run itself is tracked regardless.
  always_comb begin
    z_d     = (state_d == S_MATCH) && allowed(mode, run_bit_d);
    pulse_d = z_d && !z_q;
    hit_inc = pulse_d && !clear_hits;
  end

  sat_counter #(.W(LEN_W)) u_run_len (
    .clk    (clk),
    .reset  (reset),
    .clr    (en && new_run),
    .inc    (en),
    .max_en (1'b1),
    .max    (LEN_W'(RUN_LEN)),
    .q      (run_len_q)
  );

  sat_counter #(.W(HIT_W)) u_hit_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (clear_hits),
    .inc    (hit_inc),
    .max_en (1'b1),
    .max    ({HIT_W{1'b1}}),
    .q      (hit_cnt)
  );

  assign z       = z_q;
  assign z_pulse = pulse_q;
  assign run_bit = run_bit_q;
  assign run_len = run_len_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed and random stimulus against a history-based model
// of the run-length detector (RUN_LEN=4, HIT_W=2).
module tb_run_length_detector;

  localparam int RL  = 4;
  localparam int LW  = $clog2(RL + 1);
  localparam int HW  = 2;
  localparam int HMX = (1 << HW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          w;
  logic [1:0]    mode;
  logic          clear_hits;
  logic          z;
  logic          z_pulse;
  logic          run_bit;
  logic [LW-1:0] run_len;
  logic [HW-1:0] hit_cnt;

  int errors = 0;
  int checks = 0;

  bit hist[$];
  bit zm;
  bit pm;
  int hm;

  always #5 clk = ~clk;

  run_length_detector #(
    .RUN_LEN (RL),
    .HIT_W   (HW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .w          (w),
    .mode       (mode),
    .clear_hits (clear_hits),
    .z          (z),
    .z_pulse    (z_pulse),
    .run_bit    (run_bit),
    .run_len    (run_len),
    .hit_cnt    (hit_cnt)
  );

  function automatic int trail_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) n++;
      else break;
    end
    return (n > RL) ? RL : n;
  endfunction

  function automatic bit ok(input logic [1:0] m, input bit b);
    return (m == 2'd0) || (m == 2'd1 && b) || (m == 2'd2 && !b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit e, input bit b, input logic [1:0] m,
                      input bit c, input bit r);
    bit nz;
    bit last;
    en = e; w = b; mode = m; clear_hits = c; reset = r;
    @(posedge clk);
    if (r) begin
      hist.delete();
      zm = 0; pm = 0; hm = 0;
    end else begin
      if (e) begin
        hist.push_back(b);
        if (hist.size() > RL) void'(hist.pop_front());
      end
      last = (hist.size() > 0) ? hist[hist.size() - 1] : 1'b0;
      nz = (hist.size() > 0) && (trail_len() == RL) && ok(m, last);
      pm = nz && !zm;
      if (c) hm = 0;
      else if (pm && hm < HMX) hm = hm + 1;
      zm = nz;
    end
    #1;
    chk("z", 32'(z), 32'(zm));
    chk("z_pulse", 32'(z_pulse), 32'(pm));
    chk("run_bit", 32'(run_bit),
        32'((hist.size() > 0) ? hist[hist.size() - 1] : 1'b0));
    chk("run_len", 32'(run_len), 32'(trail_len()));
    chk("hit_cnt", 32'(hit_cnt), 32'(hm));
  endtask

  initial begin
    bit rb;
    logic [1:0] rm;
    en = 0; w = 0; mode = 0; clear_hits = 0; reset = 1;
    step(0, 0, 2'b00, 0, 1);
    step(0, 0, 2'b00, 0, 1);
    // four zeros, hold, then flip
    for (int i = 0; i < 4; i++) step(1, 0, 2'b00, 0, 0);
    chk("dir_match_z", 32'(z), 32'd1);
    chk("dir_match_len", 32'(run_len), 32'(RL));
    for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 0, 0);
    chk("dir_hold_pulse", 32'(z_pulse), 32'd0);
    step(1, 1, 2'b00, 0, 0);
    chk("dir_flip_z", 32'(z), 32'd0);
    chk("dir_flip_len", 32'(run_len), 32'd1);
    // ones-only mode
    step(0, 0, 2'b00, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 2'b01, 0, 0);
    chk("dir_ones_noz", 32'(z), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 2'b01, 0, 0);
    chk("dir_ones_z", 32'(z), 32'd1);
    chk("dir_ones_hit", 32'(hit_cnt), 32'd1);
    // gapped run
    step(1, 0, 2'b00, 0, 0);
    step(1, 1, 2'b00, 0, 0);
    step(1, 1, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00, 0, 0);
    chk("dir_gap_len", 32'(run_len), 32'd2);
    step(1, 1, 2'b00, 0, 0);
    step(1, 1, 2'b00, 0, 0);
    chk("dir_gap_z", 32'(z), 32'd1);
    // disabled then re-enabled while matching, clear coinciding
    step(1, 1, 2'b11, 0, 0);
    chk("dir_off_z", 32'(z), 32'd0);
    step(0, 1, 2'b00, 0, 0);
    chk("dir_on_pulse", 32'(z_pulse), 32'd1);
    step(0, 1, 2'b11, 0, 0);
    step(0, 1, 2'b00, 1, 0);
    chk("dir_clr_prio", 32'(hit_cnt), 32'd0);
    // reset mid-run
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 1);
    chk("dir_rst_len", 32'(run_len), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 0, 0);
    chk("dir_rst_noz", 32'(z), 32'd0);
    // saturation with five matches
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) step(1, k[0], 2'b00, 0, 0);
    end
    chk("dir_sat", 32'(hit_cnt), 32'(HMX));
    // random runs
    rb = 0; rm = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
      step($urandom_range(0, 4) != 0, rb, rm,
           $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
